id_ex_stage: RTL

ID/EX pipeline register for the 5-stage RV32I core, with load-use hazard detection and ecall halt sequencing. It sits directly downstream of the control unit and decode logic and produces the `stall` that the control unit consumes. It latches decoded control signals, operands and register indices into EX. It inserts bubbles on hazards and runs a drain/halt state machine when a halting ecall is accepted.

---
 rtl/id_ex_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: latches decoded ID state into EX, inserts
// bubbles on load-use / ecall-x17 hazards and drains then halts on an ecall with a7 == 10.
module id_ex_stage #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic        id_mem_read,
    input  logic        id_mem_to_reg,
    input  logic        id_mem_write,
    input  logic        id_alu_src,
    input  logic        id_reg_write,
    input  logic        id_is_ecall,
    input  logic        id_x17_is_10,

    output logic        stall,

    output logic        ex_mem_read,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_write,
    output logic        ex_alu_src,
    output logic        ex_reg_write,
    output logic        ex_is_ecall,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_funct,
    output logic [6:0]  ex_opcode,
    output logic        is_halted
);

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [4:0] RegA7   = 5'd17;
    localparam logic [1:0] CntLast = 2'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    typedef struct packed {
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic        is_ecall;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  funct;
        logic [6:0]  opcode;
    } ex_t;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    ex_t        ex_q, ex_d, id_bundle;
    logic       halted_q, halted_d;

    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       rs1_used, rs2_used;
    logic       load_use, ecall_dep, hazard;
    logic       capture;

    assign id_opcode = id_inst[6:0];
    assign id_rd     = id_inst[11:7];
    assign id_rs1    = id_inst[19:15];
    assign id_rs2    = id_inst[24:20];

    // Only opcodes that actually read a source register can create a dependency.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode)
            OpReg, OpStore: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OpImm, OpLoad: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use = ex_q.mem_read && (ex_q.rd != 5'd0) &&
                      ((rs1_used && (ex_q.rd == id_rs1)) || (rs2_used && (ex_q.rd == id_rs2)));
    // ecall decides halting from the x17 read in ID, so an in-flight write to x17 must land first.
    assign ecall_dep = id_is_ecall && ex_q.reg_write && (ex_q.rd == RegA7);
    assign hazard    = load_use || ecall_dep;

    always_comb begin
        id_bundle.mem_read   = id_mem_read;
        id_bundle.mem_to_reg = id_mem_to_reg;
        id_bundle.mem_write  = id_mem_write;
        id_bundle.alu_src    = id_alu_src;
        id_bundle.reg_write  = id_reg_write;
        id_bundle.is_ecall   = id_is_ecall;
        id_bundle.pc         = id_pc;
        id_bundle.rs1_data   = id_rs1_data;
        id_bundle.rs2_data   = id_rs2_data;
        id_bundle.imm        = id_imm;
        id_bundle.rs1        = id_rs1;
        id_bundle.rs2        = id_rs2;
        id_bundle.rd         = id_rd;
        id_bundle.funct      = {id_inst[30], id_inst[14:12]};
        id_bundle.opcode     = id_opcode;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b1;
        capture = 1'b0;
        unique case (state_q)
            StRun: begin
                stall   = hazard;
                capture = !hazard;
                if (capture && id_is_ecall && id_x17_is_10) begin
                    state_d = StDrain;
                    cnt_d   = 2'd0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == CntLast) begin
                    state_d = StHalted;
                end
            end
            StHalted: ;
            default: state_d = StRun;
        endcase
    end

    // Bubbles clear the whole bundle, not only the control bits.
    assign ex_d     = capture ? id_bundle : '0;
    assign halted_d = (state_d == StHalted);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StRun;
            cnt_q    <= 2'd0;
            ex_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ex_q     <= ex_d;
            halted_q <= halted_d;
        end
    end

    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_is_ecall   = ex_q.is_ecall;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct      = ex_q.funct;
    assign ex_opcode     = ex_q.opcode;
    assign is_halted     = halted_q;

endmodule
